// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory side signals of the two-port memory arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LINE_W = 128
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              done0;
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              done1;
  logic [LINE_W-1:0] rdata;
  logic              busy;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  // The arbiter side.
  modport master (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata, mem_ready,
    output done0, done1, rdata, busy, mem_read, mem_write, mem_addr, mem_wdata
  );

  // The cache controllers and memory side.
  modport slave (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata, mem_ready,
    input  done0, done1, rdata, busy, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one main memory between two cache controllers
module mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LINE_W = 128
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_d;
  logic              last_grant, last_grant_d;
  logic              grant;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
    end
  end

  // last_grant doubles as the owner of the in-flight access.
  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    rd_d         = rd_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    grant        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant        = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
          last_grant_d = grant;
          addr_d       = grant ? bus.addr1  : bus.addr0;
          wdata_d      = grant ? bus.wdata1 : bus.wdata0;
          wr_d         = grant ? bus.we1    : bus.we0;
          rd_d         = ~wr_d;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.mem_ready) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (rd_q)
            rdata_d = bus.mem_rdata;
          done0_d = ~last_grant;
          done1_d = last_grant;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state != IDLE);
  assign bus.mem_read  = rd_q;
  assign bus.mem_write = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized check of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LINE_W = 128;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total  = 0;
  int passed = 0;

  // Model state: which port won last, and the line the arbiter should be holding.
  bit           model_last;
  logic [127:0] model_rdata;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    model_last  = 1'b1;
    model_rdata = '0;
  endtask

  // One complete request from IDLE back to IDLE; memory answers on the lat-th ACCESS cycle.
  task automatic do_access(input bit r0, input bit r1, input bit w0, input bit w1,
                           input logic [9:0] a0, input logic [9:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input int lat, input logic [127:0] line, input bit poke_other);
    bit          win;
    bit          wwe;
    logic [9:0]  wa;
    logic [31:0] wd;
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    win        = (r0 && r1) ? ~model_last : r1;
    model_last = win;
    wwe = win ? w1 : w0;
    wa  = win ? a1 : a0;
    wd  = win ? d1 : d0;
    tick();
    for (int k = 0; k < lat; k++) begin
      if (k > 0) tick();
      chk("mem_read",  128'(bus.mem_read),  128'(!wwe));
      chk("mem_write", 128'(bus.mem_write), 128'(wwe));
      chk("mem_addr",  128'(bus.mem_addr),  128'(wa));
      chk("mem_wdata", 128'(bus.mem_wdata), 128'(wd));
      chk("busy_acc",  128'(bus.busy),      128'(1'b1));
      chk("done_acc",  128'({bus.done1, bus.done0}), 128'(2'b00));
      bus.addr0  = 10'($urandom);
      bus.addr1  = 10'($urandom);
      bus.wdata0 = $urandom;
      bus.wdata1 = $urandom;
      if (poke_other || ($urandom_range(0, 1) == 1)) begin
        if (win) begin bus.req0 = 1'b1; bus.we0 = 1'($urandom); end
        else     begin bus.req1 = 1'b1; bus.we1 = 1'($urandom); end
      end
      if (k == lat - 1) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = line;
      end
    end
    tick();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = rand_line();
    if (!wwe) model_rdata = line;
    chk("done0_resp", 128'(bus.done0), 128'(!win));
    chk("done1_resp", 128'(bus.done1), 128'(win));
    chk("rdata_resp", bus.rdata, model_rdata);
    chk("strobes_resp", 128'({bus.mem_read, bus.mem_write}), 128'(2'b00));
    chk("busy_resp", 128'(bus.busy), 128'(1'b1));
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();
    chk("done_idle", 128'({bus.done1, bus.done0}), 128'(2'b00));
    chk("busy_idle", 128'(bus.busy), 128'(1'b0));
    chk("rdata_idle", bus.rdata, model_rdata);
  endtask

  initial begin
    reset = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    model_reset();
    tick();
    tick();
    chk("rst_done",    128'({bus.done1, bus.done0}), 128'(2'b00));
    chk("rst_strobes", 128'({bus.mem_read, bus.mem_write}), 128'(2'b00));
    chk("rst_addr",    128'(bus.mem_addr), 128'(0));
    chk("rst_wdata",   128'(bus.mem_wdata), 128'(0));
    chk("rst_rdata",   bus.rdata, 128'(0));
    chk("rst_busy",    128'(bus.busy), 128'(1'b0));
    reset = 1'b0;
    tick();

    do_access(1, 0, 0, 0, 10'h05A, 10'h000, 32'h0, 32'h0, 4, {16{8'hA5}}, 0);
    do_access(0, 1, 0, 1, 10'h000, 10'h3FF, 32'h0, 32'hDEADBEEF, 2, rand_line(), 0);

    bus.mem_ready = 1'b1;
    bus.mem_rdata = rand_line();
    tick();
    bus.mem_ready = 1'b0;
    chk("stray_done",    128'({bus.done1, bus.done0}), 128'(2'b00));
    chk("stray_busy",    128'(bus.busy), 128'(1'b0));
    chk("stray_strobes", 128'({bus.mem_read, bus.mem_write}), 128'(2'b00));
    chk("stray_rdata",   bus.rdata, model_rdata);
    tick();
    chk("stray_done2",   128'({bus.done1, bus.done0}), 128'(2'b00));

    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    for (int i = 0; i < 4; i++)
      do_access(1, 1, 1'($urandom), 1'($urandom), 10'($urandom), 10'($urandom),
                $urandom, $urandom, $urandom_range(1, 3), rand_line(), 0);

    do_access(1, 0, 0, 0, 10'h111, 10'h222, 32'h0, 32'h0, 3, rand_line(), 1);
    do_access(0, 1, 0, 0, 10'h111, 10'h222, 32'h0, 32'h0, 1, rand_line(), 0);

    do_access(1, 0, 0, 0, 10'h010, 10'h000, 32'h0, 32'h0, 1, rand_line(), 0);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 10'h123;
    tick();
    chk("pre_rst_read", 128'(bus.mem_read), 128'(1'b1));
    tick();
    reset = 1'b1;
    #1;
    chk("rst_mid_read", 128'(bus.mem_read), 128'(1'b0));
    chk("rst_mid_busy", 128'(bus.busy), 128'(1'b0));
    chk("rst_mid_done", 128'({bus.done1, bus.done0}), 128'(2'b00));
    model_reset();
    bus.req0 = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_done", 128'({bus.done1, bus.done0}), 128'(2'b00));
    do_access(1, 1, 0, 0, 10'h045, 10'h046, 32'h0, 32'h0, 2, rand_line(), 0);

    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(1, 3);
      do_access(r[0], r[1], 1'($urandom), 1'($urandom), 10'($urandom), 10'($urandom),
                $urandom, $urandom, $urandom_range(1, 5), rand_line(), 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
